// File: rtl/sha_pad_sequencer.sv
// sha_pad_sequencer
// Streaming SHA-256 message padder and 512-bit block sequencer.
// Accepts big-endian 32-bit message words and emits 16-word blocks in which
// each word is a pass-through message word, the 0x80 marker, zero fill, or
// one half of the 64-bit message bit length. Messages of any length are
// handled, spanning as many blocks as needed.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  message word handshake
//   in_data         message word, byte 0 in [31:24]
//   in_nbytes       valid bytes (left-justified); 0 only on an empty final word,
//                   5..7 treated as 4
//   in_last         final word of the message
//   out_valid/ready padded word handshake (single registered output stage)
//   out_data        padded block word
//   out_idx         word index within the block (0..15)
//   out_block_last  high with out_idx==15 on every block
//   out_msg_last    high on the final word of the final block of a message
module sha_pad_sequencer #(
    parameter int unsigned LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_nbytes,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_block_last,
    output logic        out_msg_last
);

    localparam logic [2:0] ST_MSG    = 3'd0;
    localparam logic [2:0] ST_MARK   = 3'd1;
    localparam logic [2:0] ST_ZERO   = 3'd2;
    localparam logic [2:0] ST_LEN_HI = 3'd3;
    localparam logic [2:0] ST_LEN_LO = 3'd4;

    logic [2:0]       state;
    logic [LEN_W-1:0] bitcnt;
    logic [3:0]       widx;      // index of the next word to be emitted
    logic [3:0]       widx_nxt;
    logic             load;
    logic [63:0]      len64;

    logic [2:0]       nb;
    logic [31:0]      last_word;
    logic             emit;
    logic [31:0]      nxt_data;
    logic [2:0]       nxt_state;
    logic             nxt_mlast;
    logic [2:0]       fill_state;
    logic [LEN_W-1:0] cnt_add;
    logic             cnt_clr;

    assign load     = !out_valid || out_ready;
    assign in_ready = (state == ST_MSG) && load;
    assign widx_nxt = widx + 4'd1;
    assign len64    = 64'(bitcnt);

    // After the marker word, skip straight to the length when it already
    // lands on index 14; otherwise zero-fill (possibly across a block wrap).
    assign fill_state = (widx_nxt == 4'd14) ? ST_LEN_HI : ST_ZERO;

    always_comb begin
        nb = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
        case (nb)
            3'd0:    last_word = 32'h8000_0000;
            3'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
            3'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
            3'd3:    last_word = {in_data[31:8], 8'h80};
            default: last_word = in_data;
        endcase
    end

    always_comb begin
        emit      = 1'b0;
        nxt_data  = '0;
        nxt_state = state;
        nxt_mlast = 1'b0;
        cnt_add   = '0;
        cnt_clr   = 1'b0;
        case (state)
            ST_MSG: begin
                if (in_valid) begin
                    emit = 1'b1;
                    if (!in_last) begin
                        nxt_data = in_data;
                        cnt_add  = LEN_W'(32);
                    end else if (nb == 3'd4) begin
                        nxt_data  = in_data;
                        cnt_add   = LEN_W'(32);
                        nxt_state = ST_MARK;
                    end else begin
                        nxt_data  = last_word;
                        cnt_add   = LEN_W'({nb, 3'b000});
                        nxt_state = fill_state;
                    end
                end
            end
            ST_MARK: begin
                emit      = 1'b1;
                nxt_data  = 32'h8000_0000;
                nxt_state = fill_state;
            end
            ST_ZERO: begin
                emit      = 1'b1;
                nxt_state = fill_state;
            end
            ST_LEN_HI: begin
                emit      = 1'b1;
                nxt_data  = len64[63:32];
                nxt_state = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                emit      = 1'b1;
                nxt_data  = len64[31:0];
                nxt_mlast = 1'b1;
                cnt_clr   = 1'b1;
                nxt_state = ST_MSG;
            end
            default: nxt_state = ST_MSG;
        endcase
    end

    // widx is 15 when LEN_LO is emitted, so the natural wrap returns it to 0
    // at every message end.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_MSG;
            bitcnt         <= '0;
            widx           <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_idx        <= '0;
            out_block_last <= 1'b0;
            out_msg_last   <= 1'b0;
        end else if (load) begin
            out_valid <= emit;
            state     <= nxt_state;
            if (emit) begin
                out_data       <= nxt_data;
                out_idx        <= widx;
                out_block_last <= (widx == 4'd15);
                out_msg_last   <= nxt_mlast;
                widx           <= widx_nxt;
                bitcnt         <= cnt_clr ? '0 : bitcnt + cnt_add;
            end
        end
    end

endmodule

// File: tb/tb_sha_pad_sequencer.sv
// tb_sha_pad_sequencer
// Directed bench for sha_pad_sequencer. Expected words come from a byte-level
// model of SHA-256 padding (append 0x80, zero to 56 mod 64, append 64-bit
// bit length) and are checked on every output transfer.
module tb_sha_pad_sequencer;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] d;
        logic [3:0]  idx;
        logic        bl;
        logic        ml;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [2:0]  in_nbytes = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [3:0]  out_idx;
    logic        out_block_last;
    logic        out_msg_last;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit bp_mode = 1'b0;
    int bp_cnt = 0;

    exp_t        exp_q[$];
    logic [31:0] pad_w[$];
    bq_t         msg;

    bit          msg_start = 1'b1;
    int          first_cyc = 0;
    int          last_cyc = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] held_data;
    logic [3:0]  held_idx;

    sha_pad_sequencer #(.LEN_W(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_nbytes(in_nbytes), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_block_last(out_block_last),
        .out_msg_last(out_msg_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: always 1, or the repeating 1,0,0 pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_ready = (bp_cnt % 3 == 0);
                bp_cnt++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Padded word stream of a message, straight from the padding rule.
    function automatic void build_pad(input bq_t m);
        bq_t p;
        logic [63:0] bits;
        p = m;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(m.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        pad_w.delete();
        for (int w = 0; w < p.size() / 4; w++)
            pad_w.push_back({p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]});
    endfunction

    function automatic void push_expected(input bq_t m);
        exp_t e;
        build_pad(m);
        for (int w = 0; w < pad_w.size(); w++) begin
            e.d   = pad_w[w];
            e.idx = 4'(w % 16);
            e.bl  = (w % 16 == 15);
            e.ml  = (w == pad_w.size() - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic void make_msg(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'(i * 37 + 11));
    endfunction

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int n;
        n = 0;
        in_valid  = 1'b1;
        in_data   = d;
        in_nbytes = nb;
        in_last   = last;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
                finish_sim();
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Word view of msg; unused trailing bytes carry junk.
    function automatic logic [31:0] msg_word(input int w, input logic [7:0] junk);
        logic [31:0] d;
        for (int b = 0; b < 4; b++)
            d[31-8*b -: 8] = (4*w + b < msg.size()) ? msg[4*w+b] : junk;
        return d;
    endfunction

    task automatic send_msg(input logic [7:0] junk);
        int nw;
        int rem;
        push_expected(msg);
        if (msg.size() == 0) begin
            send_word(32'hDEADBEEF, 3'd0, 1'b1);
        end else begin
            nw = (msg.size() + 3) / 4;
            for (int w = 0; w < nw; w++) begin
                rem = msg.size() - 4*w;
                send_word(msg_word(w, junk), (rem >= 4) ? 3'd4 : 3'(rem), w == nw - 1);
            end
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words still outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Compare process: every transfer against the model, plus stall checks.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            msg_start  = 1'b1;
        end else begin
            if (prev_stall && out_valid) begin
                check("stall_data", 64'(out_data), 64'(held_data));
                check("stall_idx", 64'(out_idx), 64'(held_idx));
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                prev_stall = 1'b1;
                held_data  = out_data;
                held_idx   = out_idx;
            end else begin
                prev_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got data %08h idx %0d, required no word", out_data, out_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d || out_idx !== e.idx ||
                        out_block_last !== e.bl || out_msg_last !== e.ml) begin
                        errors++;
                        $display("FAIL word: got data %08h idx %0d bl %0b ml %0b, required data %08h idx %0d bl %0b ml %0b",
                                 out_data, out_idx, out_block_last, out_msg_last, e.d, e.idx, e.bl, e.ml);
                    end
                end
                if (msg_start) begin
                    first_cyc = cyc;
                    msg_start = 1'b0;
                end
                if (out_msg_last) begin
                    last_cyc  = cyc;
                    msg_start = 1'b1;
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_block_last", 64'(out_block_last), 64'd0);
        check("rst_msg_last", 64'(out_msg_last), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Pin the model with hand-derived words.
        msg = '{8'h61, 8'h62, 8'h63};
        build_pad(msg);
        check("model_abc_w0", 64'(pad_w[0]), 64'h61626380);
        check("model_abc_w15", 64'(pad_w[15]), 64'h00000018);
        make_msg(56);
        build_pad(msg);
        check("model_56_size", 64'(pad_w.size()), 64'd32);
        check("model_56_w14", 64'(pad_w[14]), 64'h80000000);
        check("model_56_w31", 64'(pad_w[31]), 64'h000001C0);
        make_msg(55);
        build_pad(msg);
        check("model_55_w15", 64'(pad_w[15]), 64'h000001B8);
        check("model_55_w13_lo", 64'(pad_w[13][7:0]), 64'h80);

        // "abc": 16 words in 16 consecutive cycles.
        @(posedge clk);
        #1;
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(8'h00);
        wait_drain();
        check("abc_span", 64'(last_cyc - first_cyc), 64'd15);

        // Empty, 56, 55 then abc back-to-back, and marker positions 13/15/0.
        msg.delete();
        send_msg(8'hA5);
        wait_drain();
        make_msg(56);
        send_msg(8'hA5);
        wait_drain();
        make_msg(55);
        send_msg(8'hA5);
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(8'h00);
        wait_drain();
        make_msg(61);
        send_msg(8'hA5);
        make_msg(62);
        send_msg(8'hA5);
        make_msg(63);
        send_msg(8'hA5);
        make_msg(64);
        send_msg(8'hA5);
        make_msg(130);
        send_msg(8'hA5);
        wait_drain();

        // Backpressure.
        bp_mode = 1'b1;
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(8'h00);
        wait_drain();
        make_msg(57);
        send_msg(8'hA5);
        wait_drain();
        bp_mode = 1'b0;
        @(posedge clk);
        #1;

        // Reset after 5 words of a 20-word message.
        make_msg(80);
        push_expected(msg);
        for (int w = 0; w < 5; w++) send_word(msg_word(w, 8'hA5), 3'd4, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (5) @(negedge clk);
        check("midrst_quiet", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        msg = '{8'h61, 8'h62, 8'h63};
        send_msg(8'h00);
        wait_drain();
        check("midrst_abc_span", 64'(last_cyc - first_cyc), 64'd15);

        finish_sim();
    end

endmodule

// File: doc/sha_pad_sequencer.md
Name: sha_pad_sequencer

Overview:
- Streaming SHA-256 message padder and block sequencer for messages of arbitrary length.
- Accepts big-endian 32-bit message words on a valid/ready stream.
- Emits 16-word 512-bit blocks to the compression core. Each output word is a pass-through message word, the 0x80 marker, zero fill, or the 64-bit length field.
- Sits between the message source and the SHA-256 message schedule. Multi-block messages are handled, unlike a fixed-size combinational padder.

Parameters:
- LEN_W, 64, width of the internal bit-length counter (33..64). It is zero-extended to 64 bits in the length field and wraps modulo 2^LEN_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  message word valid
- in_ready  out  1  sequencer accepts a message word
- in_data  in  32  message word; byte 0 is in [31:24]
- in_nbytes  in  3  valid bytes in in_data, left-justified. Legal values are 1..4. A value of 0 is legal only with in_last and marks an empty final word. Values 5..7 are treated as 4.
- in_last  in  1  final word of the message
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts the word
- out_data  out  32  padded block word
- out_idx  out  4  word index within the block (0..15)
- out_block_last  out  1  high with out_idx==15 on every block
- out_msg_last  out  1  high with out_idx==15 of the final block of a message

Behaviour:
- Reset and output register:
  - Reset gives: out_valid=0, out_data=0, out_idx=0, out_block_last=0, out_msg_last=0, bit counter=0, word index=0, state=MSG.
  - The output is a single register stage. It loads when !out_valid || out_ready, so there is 1-cycle latency from input acceptance to out_valid.
  - A word is transferred when out_valid && out_ready. out_* are held stable while out_valid && !out_ready.
  - in_ready = (state==MSG) && (!out_valid || out_ready). It is 0 in every other state.
- State MSG, non-last word:
  - Emit in_data and add 32 to the bit counter.
- State MSG, last word with nbytes 1..3:
  - Emit the valid bytes, byte 0x80 in the next byte position, and zeros below it.
  - Add 8*nbytes to the bit counter, then go to ZERO.
- State MSG, last word with nbytes 4:
  - Emit in_data and add 32 to the bit counter, then go to MARK.
- State MSG, last word with nbytes 0:
  - Emit 0x80000000 and add nothing to the bit counter, then go to ZERO.
- State MARK:
  - Emit 0x80000000, then go to ZERO.
- State ZERO:
  - Emit 0x00000000 until the next word to emit has index 14.
  - If the marker landed at index 14 or 15, fill to index 15, wrap to the next block, and emit zeros at indices 0..13.
  - Go to LEN_HI when the next index is 14.
- State LEN_HI:
  - Emit bits [63:32] of the zero-extended bit counter.
- State LEN_LO:
  - Emit bits [31:0] of the bit counter with out_msg_last=1.
  - Clear the counter and go to MSG.
- Word index:
  - Increments on every word loaded into the output register and wraps 15→0.
  - Returns to 0 exactly at each message end.
  - The MSG→ZERO and MARK→ZERO transitions are evaluated using the post-increment index. Wrap-around has no special-case gaps: the block is always exactly 16 words.
- Message boundary: a new message may start on the cycle after LEN_LO is loaded, with no idle cycle required.
- Reset mid-message: the partial block is discarded, all state returns to reset values, and no further words are emitted.
- Counter overflow: the counter wraps silently modulo 2^LEN_W.

Test Plan:
- "abc": one word 0x61626300, nbytes=3, last, out_ready=1.
  - Expect 16 words: 0x61626380, then 14×0x00000000, then 0x00000018 at idx15.
  - out_msg_last=1 on the 16th word, and 16 transfers in 16 consecutive cycles after the first.
- Empty message: in_data=x, nbytes=0, last.
  - Expect 0x80000000, then 14 zeros, then 0x00000000 with out_msg_last=1.
- 56-byte message: 14 full words, the last with nbytes=4.
  - Block 1: 14 data words, 0x80000000 at idx14, 0 at idx15, out_msg_last=0.
  - Block 2: 14 zeros, then 0x00000000, then 0x000001C0 with out_msg_last=1.
- 55-byte message: last word nbytes=3.
  - Word idx13 is {3 bytes, 0x80}, then the length 0x000001B8 follows in the same block with out_msg_last=1.
- Backpressure: run "abc" with out_ready toggling 1,0,0,1,...
  - The output word sequence is identical.
  - out_data/out_idx are stable while stalled.
  - in_ready=0 whenever out_valid && !out_ready.
- Reset mid-message: assert rst after 5 words are accepted of a 20-word message.
  - Next cycle: out_valid=0 and in_ready=1.
  - A following "abc" message produces the exact "abc" block.
